lane_read_eye_trainer: RTL and testbench
========================================

Name: lane_read_eye_trainer

Overview:
- Fabric-side controller for one DQ lane's IOD read-training interface.
- Drives the IOD's dynamic input delay line (LOAD/MOVE/DIRECTION) and clears and samples the IOD eye-monitor EARLY/LATE flags.
- Sweeps taps upward, finds the first passing window of at least MIN_EYE taps, then steps the delay line back to the window centre.
- Sits between the PHY training sequencer and one lane's IOD read-training wrapper. One instance per DQ bit.

Parameters:
- TAP_MAX, 127: highest legal delay tap; the sweep never moves past it.
- SETTLE_CYCLES, 8: idle cycles after a tap change or flag clear, before sampling starts.
- SAMPLE_CYCLES, 16: cycles over which EARLY/LATE are observed per tap.
- MIN_EYE, 4: minimum passing-window width in taps. Narrower windows are discarded.

Ports:
- FAB_CLK  in  1  fabric clock; all logic is on the rising edge.
- SYNC_RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request; accepted only in IDLE.
- BUSY  out  1  high from the cycle after START is accepted until DONE or ERROR rises.
- DONE  out  1  level; training succeeded; cleared when the next START is accepted.
- ERROR  out  1  level; no valid window found; cleared when the next START is accepted.
- DELAY_LINE_LOAD  out  1  one-cycle pulse; resets the IOD delay to tap 0.
- DELAY_LINE_MOVE  out  1  one-cycle pulse; steps the delay by one tap.
- DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; valid in the MOVE cycle.
- DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line limit flag.
- EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse; clears the IOD sticky flags.
- EYE_MONITOR_EARLY  in  1  IOD early flag.
- EYE_MONITOR_LATE  in  1  IOD late flag.
- TAP_POS  out  8  tracked current tap.
- EYE_LEFT  out  8  first passing tap of the accepted window.
- EYE_RIGHT  out  8  last passing tap of the accepted window.

Behaviour:
- Reset: every output is 0, including pulses, TAP_POS, EYE_LEFT and EYE_RIGHT; the FSM goes to IDLE.
- Reset mid-operation aborts immediately. No further pulses are issued, and the IOD delay is not restored.
- FSM states:
  - IDLE -> LOAD on START. A START during BUSY is ignored.
  - LOAD: DELAY_LINE_LOAD=1 for 1 cycle; TAP_POS<=0; go to CLEAR.
  - CLEAR: EYE_MONITOR_CLEAR_FLAGS=1 for 1 cycle; go to SETTLE.
  - SETTLE: wait SETTLE_CYCLES; go to SAMPLE.
  - SAMPLE: for SAMPLE_CYCLES, fail |= EARLY|LATE; go to EVAL.
  - EVAL: the tap passes iff fail==0. Window tracking:
    - pass with no window open: open window, cand_left=TAP_POS.
    - fail with a window open: close it at TAP_POS-1. Width = right-left+1. If width>=MIN_EYE, accept and go to CENTER; otherwise discard and continue.
    - end condition (TAP_POS==TAP_MAX, or OUT_OF_RANGE sampled high in EVAL): close any open window at TAP_POS and apply the same width rule. If nothing is accepted -> FAIL_END.
    - otherwise -> INC.
  - INC: MOVE=1 with DIRECTION=1 for 1 cycle; TAP_POS+1; go to CLEAR.
  - CENTER:
    - target = (EYE_LEFT+EYE_RIGHT)>>1, computed as a 9-bit sum, truncated.
    - while TAP_POS>target: MOVE=1 with DIRECTION=0 for 1 cycle, TAP_POS-1, then 1 idle cycle.
    - at TAP_POS==target: DONE<=1, BUSY<=0 -> IDLE.
  - FAIL_END: ERROR<=1, BUSY<=0, no centering -> IDLE.
- Per-tap cost: 1 (CLEAR) + SETTLE_CYCLES + SAMPLE_CYCLES + 1 (EVAL) + 1 (INC) cycles.
- MOVE and LOAD are never asserted in the same cycle.
- DIRECTION holds its last value outside MOVE cycles.
- EYE_LEFT/EYE_RIGHT update only on acceptance; they hold their values after DONE.

Optional Feature:
- Macro: LANE_READ_EYE_TRAINER_RETRY_EN.
- Defined: the first FAIL_END does not raise ERROR. The trainer instead re-enters LOAD once with the effective sample window 2*SAMPLE_CYCLES. ERROR is raised only if the retry also fails. BUSY stays high across the retry.
- Undefined: FAIL_END raises ERROR directly. No retry logic is synthesised.

Decomposition:
- Package lane_read_eye_trainer_pkg holds:
  - the state enum (IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, INC, CENTER, FAIL_END);
  - DIR_INC=1'b1 and DIR_DEC=1'b0;
  - the tap width constant (8).
- Sub-module eye_window_tracker holds the open/close/accept logic and the cand_left/width compare. Its inputs are the eval strobe, pass, end and TAP_POS; its outputs are accept, EYE_LEFT and EYE_RIGHT.

Test Plan:
- Eye model fails when tap<20 or tap>60; pulse START. Required: EYE_LEFT=20, EYE_RIGHT=60, 61 INC pulses, then 21 DIRECTION=0 pulses, TAP_POS=40, DONE=1, ERROR=0.
- Passes only at taps 30..32 and 70..90. Required: the first window is discarded (width 3); EYE_LEFT=70, EYE_RIGHT=90, final TAP_POS=80, DONE=1.
- Always failing. Required: 127 INC pulses, TAP_POS=127, ERROR=1, DONE=0, no decrement pulses; with RETRY_EN, ERROR rises only after a second full sweep.
- Passes at taps 100..127 (window reaches the end). Required: EYE_RIGHT=127, target 113, 14 decrement pulses, DONE=1.
- OUT_OF_RANGE forced high at tap 50 while passing from 10. Required: EYE_RIGHT=50, centre 30, DONE=1.
- SYNC_RST asserted mid-SAMPLE at tap 15, plus START pulsed during BUSY. Required: reset gives all outputs 0 the next cycle and IDLE; the START during BUSY is ignored, with no extra LOAD pulse.

Source files
------------

// File: rtl/lane_read_eye_trainer_pkg.sv
// Shared types and constants for the lane read-eye trainer.
package lane_read_eye_trainer_pkg;

    localparam int TAP_W = 8;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        CLEAR,
        SETTLE,
        SAMPLE,
        EVAL,
        INC,
        CENTER,
        FAIL_END
    } state_t;

endpackage

// File: rtl/lane_read_eye_trainer_window.sv
// eye_window_tracker: follows the passing-tap window during the sweep and
// latches the first window that is at least MIN_EYE taps wide.
import lane_read_eye_trainer_pkg::*;

module eye_window_tracker #(
    parameter int MIN_EYE = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_eval,
    input  logic             i_pass,
    input  logic             i_end,
    input  logic [TAP_W-1:0] i_tap,
    output logic             o_accept,
    output logic [TAP_W-1:0] o_eye_left,
    output logic [TAP_W-1:0] o_eye_right
);

    localparam logic [TAP_W:0] MIN_W = (TAP_W + 1)'(MIN_EYE);

    logic             r_open;
    logic [TAP_W-1:0] r_cand_left;
    logic [TAP_W-1:0] r_eye_left;
    logic [TAP_W-1:0] r_eye_right;

    logic             w_close;
    logic [TAP_W-1:0] w_left;
    logic [TAP_W-1:0] w_right;
    logic [TAP_W:0]   w_width;

    // A window that opens on the last tap starts and ends at that tap.
    assign w_left   = r_open ? r_cand_left : i_tap;
    // A failing tap ends the window one tap earlier; an end-of-sweep pass ends it here.
    assign w_right  = i_pass ? i_tap : (i_tap - 1'b1);
    assign w_close  = i_eval && (r_open || i_pass) && (!i_pass || i_end);
    assign w_width  = {1'b0, w_right} - {1'b0, w_left} + 1'b1;
    assign o_accept = w_close && (w_width >= MIN_W);

    assign o_eye_left  = r_eye_left;
    assign o_eye_right = r_eye_right;

    // Open/close the candidate window and latch the accepted edges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_open      <= 1'b0;
            r_cand_left <= '0;
            r_eye_left  <= '0;
            r_eye_right <= '0;
        end else if (i_clear) begin
            r_open <= 1'b0;
        end else if (i_eval) begin
            if (w_close) begin
                r_open <= 1'b0;
            end else if (i_pass && !r_open) begin
                r_open      <= 1'b1;
                r_cand_left <= i_tap;
            end
            if (o_accept) begin
                r_eye_left  <= w_left;
                r_eye_right <= w_right;
            end
        end
    end

endmodule

// File: rtl/lane_read_eye_trainer.sv
// lane_read_eye_trainer: sweeps one DQ lane's IOD input delay, finds the
// first passing window of MIN_EYE taps or more and parks at its centre.
// Optional feature macro: LANE_READ_EYE_TRAINER_RETRY_EN (one retry sweep
// with a doubled sample window before ERROR is raised).
import lane_read_eye_trainer_pkg::*;

module lane_read_eye_trainer #(
    parameter int TAP_MAX       = 127,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16,
    parameter int MIN_EYE       = 4
) (
    input  logic             FAB_CLK,
    input  logic             SYNC_RST,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERROR,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE,
    output logic [TAP_W-1:0] TAP_POS,
    output logic [TAP_W-1:0] EYE_LEFT,
    output logic [TAP_W-1:0] EYE_RIGHT
);

    localparam int               CNT_W       = 16;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(TAP_MAX);

    state_t           r_state;
    state_t           w_state_next;
    logic [TAP_W-1:0] r_tap;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fail;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_dir;
    logic             r_wait;

    logic             w_start_ok;
    logic             w_eval;
    logic             w_pass;
    logic             w_end;
    logic             w_accept;
    logic             w_dec;
    logic             w_center_done;
    logic             w_fail_final;
    logic             w_settle_last;
    logic             w_sample_last;
    logic [CNT_W-1:0] w_sample_end;
    logic [TAP_W:0]   w_sum;
    logic [TAP_W-1:0] w_target;

`ifdef LANE_READ_EYE_TRAINER_RETRY_EN
    logic r_retried;

    assign w_sample_end = r_retried ? CNT_W'(2 * SAMPLE_CYCLES - 1) : CNT_W'(SAMPLE_CYCLES - 1);
    assign w_fail_final = r_retried;

    // Remember that the single retry sweep has been used.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_retried <= 1'b0;
        end else if (w_start_ok) begin
            r_retried <= 1'b0;
        end else if (r_state == FAIL_END) begin
            r_retried <= 1'b1;
        end
    end
`else
    assign w_sample_end = CNT_W'(SAMPLE_CYCLES - 1);
    assign w_fail_final = 1'b1;
`endif

    assign w_start_ok    = (r_state == IDLE) && START;
    assign w_eval        = (r_state == EVAL);
    assign w_pass        = !r_fail;
    assign w_end         = (r_tap == TAP_LAST) || DELAY_LINE_OUT_OF_RANGE;
    assign w_settle_last = (r_cnt == SETTLE_LAST);
    assign w_sample_last = (r_cnt == w_sample_end);
    assign w_sum         = {1'b0, EYE_LEFT} + {1'b0, EYE_RIGHT};
    assign w_target      = w_sum[TAP_W:1];
    assign w_dec         = (r_state == CENTER) && !r_wait && (r_tap > w_target);
    assign w_center_done = (r_state == CENTER) && !r_wait && (r_tap <= w_target);

    assign BUSY                 = r_busy;
    assign DONE                 = r_done;
    assign ERROR                = r_error;
    assign DELAY_LINE_DIRECTION = r_dir;
    assign TAP_POS              = r_tap;

    eye_window_tracker #(
        .MIN_EYE (MIN_EYE)
    ) u_window (
        .i_clk       (FAB_CLK),
        .i_rst       (SYNC_RST),
        .i_clear     (r_state == LOAD),
        .i_eval      (w_eval),
        .i_pass      (w_pass),
        .i_end       (w_end),
        .i_tap       (r_tap),
        .o_accept    (w_accept),
        .o_eye_left  (EYE_LEFT),
        .o_eye_right (EYE_RIGHT)
    );

    // State register.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and the one-cycle IOD strobes.
    always_comb begin
        w_state_next            = r_state;
        DELAY_LINE_LOAD         = 1'b0;
        DELAY_LINE_MOVE         = 1'b0;
        EYE_MONITOR_CLEAR_FLAGS = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) w_state_next = LOAD;
            end
            LOAD: begin
                DELAY_LINE_LOAD = 1'b1;
                w_state_next    = CLEAR;
            end
            CLEAR: begin
                EYE_MONITOR_CLEAR_FLAGS = 1'b1;
                w_state_next            = SETTLE;
            end
            SETTLE: begin
                if (w_settle_last) w_state_next = SAMPLE;
            end
            SAMPLE: begin
                if (w_sample_last) w_state_next = EVAL;
            end
            EVAL: begin
                if (w_accept)   w_state_next = CENTER;
                else if (w_end) w_state_next = FAIL_END;
                else            w_state_next = INC;
            end
            INC: begin
                DELAY_LINE_MOVE = 1'b1;
                w_state_next    = CLEAR;
            end
            CENTER: begin
                DELAY_LINE_MOVE = w_dec;
                if (w_center_done) w_state_next = IDLE;
            end
            FAIL_END: begin
                w_state_next = w_fail_final ? IDLE : LOAD;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Tap tracking, settle/sample counting, fail accumulation and status.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_tap   <= '0;
            r_cnt   <= '0;
            r_fail  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_dir   <= 1'b0;
            r_wait  <= 1'b0;
        end else begin
            if ((r_state == SETTLE && !w_settle_last) || (r_state == SAMPLE && !w_sample_last)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == CLEAR) begin
                r_fail <= 1'b0;
            end else if (r_state == SAMPLE) begin
                r_fail <= r_fail | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
            end

            if (r_state == LOAD) begin
                r_tap <= '0;
            end else if (r_state == INC) begin
                r_tap <= r_tap + 1'b1;
            end else if (w_dec) begin
                r_tap <= r_tap - 1'b1;
            end

            // Direction is set ahead of the MOVE cycles it qualifies.
            if (w_eval) begin
                if (w_accept)   r_dir <= DIR_DEC;
                else if (!w_end) r_dir <= DIR_INC;
            end

            // One idle cycle follows every centring step.
            r_wait <= w_dec;

            if (w_start_ok) begin
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end else if (w_center_done) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else if (r_state == FAIL_END && w_fail_final) begin
                r_busy  <= 1'b0;
                r_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lane_read_eye_trainer.sv
// Directed bench for lane_read_eye_trainer with a behavioural IOD model.
module tb_lane_read_eye_trainer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, error;
    logic       dl_load, dl_move, dl_dir, dl_oor;
    logic       em_clear, em_early, em_late;
    logic [7:0] tap_pos, eye_left, eye_right;

    int lo1 = 1000, hi1 = -1, lo2 = 1000, hi2 = -1;
    int oor_tap = 1000;
    logic [7:0] iod_tap = 8'd0;
    logic eye_fail;

    int n_inc = 0, n_dec = 0, n_load = 0, n_clash = 0;
    int n_chk = 0, n_pass = 0;
    int b_inc, b_dec, b_load;

    always #5 clk = ~clk;

    lane_read_eye_trainer dut (
        .FAB_CLK                 (clk),
        .SYNC_RST                (rst),
        .START                   (start),
        .BUSY                    (busy),
        .DONE                    (done),
        .ERROR                   (error),
        .DELAY_LINE_LOAD         (dl_load),
        .DELAY_LINE_MOVE         (dl_move),
        .DELAY_LINE_DIRECTION    (dl_dir),
        .DELAY_LINE_OUT_OF_RANGE (dl_oor),
        .EYE_MONITOR_CLEAR_FLAGS (em_clear),
        .EYE_MONITOR_EARLY       (em_early),
        .EYE_MONITOR_LATE        (em_late),
        .TAP_POS                 (tap_pos),
        .EYE_LEFT                (eye_left),
        .EYE_RIGHT               (eye_right)
    );

    // Eye model: a tap passes inside either configured band.
    assign eye_fail = !((int'(iod_tap) >= lo1 && int'(iod_tap) <= hi1) ||
                        (int'(iod_tap) >= lo2 && int'(iod_tap) <= hi2));
    assign em_early = eye_fail && (iod_tap < 8'd64);
    assign em_late  = eye_fail && (iod_tap >= 8'd64);
    assign dl_oor   = (int'(iod_tap) >= oor_tap);

    // IOD delay line model.
    always @(posedge clk) begin
        if (dl_load)      iod_tap <= 8'd0;
        else if (dl_move) iod_tap <= dl_dir ? iod_tap + 8'd1 : iod_tap - 8'd1;
    end

    // Pulse counters.
    always @(negedge clk) begin
        if (dl_move && dl_dir)  n_inc   <= n_inc + 1;
        if (dl_move && !dl_dir) n_dec   <= n_dec + 1;
        if (dl_load)            n_load  <= n_load + 1;
        if (dl_move && dl_load) n_clash <= n_clash + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic run_train(input int a, input int b, input int c, input int d, input int o);
        lo1 = a; hi1 = b; lo2 = c; hi2 = d; oor_tap = o;
        b_inc = n_inc; b_dec = n_dec; b_load = n_load;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 20000 && !(done || error); i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_pulses", {dl_load, dl_move, em_clear}, 0);
        chk("rst_tap", tap_pos, 0);
        rst = 1'b0;
        @(negedge clk);

        // Eye 20..60.
        run_train(20, 60, 1000, -1, 1000);
        chk("t1_left", eye_left, 20);
        chk("t1_right", eye_right, 60);
        chk("t1_inc", n_inc - b_inc, 61);
        chk("t1_dec", n_dec - b_dec, 21);
        chk("t1_tap", tap_pos, 40);
        chk("t1_iod_tap", iod_tap, 40);
        chk("t1_done", done, 1);
        chk("t1_error", error, 0);
        chk("t1_busy", busy, 0);

        // Narrow 30..32 discarded, 70..90 accepted.
        run_train(30, 32, 70, 90, 1000);
        chk("t2_left", eye_left, 70);
        chk("t2_right", eye_right, 90);
        chk("t2_inc", n_inc - b_inc, 91);
        chk("t2_tap", tap_pos, 80);
        chk("t2_done", done, 1);

        // Always failing.
        run_train(1000, -1, 1000, -1, 1000);
`ifdef LANE_READ_EYE_TRAINER_RETRY_EN
        chk("t3_inc", n_inc - b_inc, 254);
        chk("t3_load", n_load - b_load, 2);
`else
        chk("t3_inc", n_inc - b_inc, 127);
        chk("t3_load", n_load - b_load, 1);
`endif
        chk("t3_tap", tap_pos, 127);
        chk("t3_error", error, 1);
        chk("t3_done", done, 0);
        chk("t3_dec", n_dec - b_dec, 0);
        chk("t3_busy", busy, 0);
        chk("t3_left_hold", eye_left, 70);

        // Window reaching the last tap.
        run_train(100, 127, 1000, -1, 1000);
        chk("t4_left", eye_left, 100);
        chk("t4_right", eye_right, 127);
        chk("t4_dec", n_dec - b_dec, 14);
        chk("t4_tap", tap_pos, 113);
        chk("t4_done", done, 1);
        chk("t4_error", error, 0);

        // Out-of-range at tap 50 while passing from 10.
        run_train(10, 127, 1000, -1, 50);
        chk("t5_left", eye_left, 10);
        chk("t5_right", eye_right, 50);
        chk("t5_tap", tap_pos, 30);
        chk("t5_dec", n_dec - b_dec, 20);
        chk("t5_done", done, 1);
        oor_tap = 1000;

        // Reset mid-SAMPLE at tap 15, with a START during BUSY.
        lo1 = 10; hi1 = 60; lo2 = 1000; hi2 = -1;
        b_load = n_load;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_busy", busy, 1);
        chk("t6_done_clr", done, 0);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 2000 && iod_tap != 8'd15; i++) @(negedge clk);
        chk("t6_reach15", iod_tap, 15);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy_rst", busy, 0);
        chk("t6_status_rst", {done, error}, 0);
        chk("t6_tap_rst", tap_pos, 0);
        chk("t6_left_rst", eye_left, 0);
        chk("t6_right_rst", eye_right, 0);
        chk("t6_pulses_rst", {dl_load, dl_move, em_clear, dl_dir}, 0);
        rst = 1'b0;
        b_inc = n_inc; b_dec = n_dec;
        repeat (50) @(negedge clk);
        chk("t6_one_load", n_load - b_load, 1);
        chk("t6_quiet_move", (n_inc - b_inc) + (n_dec - b_dec), 0);
        chk("t6_idle_busy", busy, 0);
        chk("t6_iod_kept", iod_tap, 15);

        chk("load_move_clash", n_clash, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
